// File: rtl/pcm_pkg.sv
// Shared types for the PCM stereo packer.
//   PCM_DATA_W     : PCM sample width
//   pcm_sample_t   : one PCM sample
//   stereo_frame_t : left/right pair, as stored in the frame FIFO
//   packer_state_e : pairing FSM states
package pcm_pkg;

   localparam int unsigned PCM_DATA_W = 24;
   localparam int unsigned ERR_CNT_W  = 16;

   typedef logic [PCM_DATA_W-1:0] pcm_sample_t;

   typedef struct packed {
      pcm_sample_t left;
      pcm_sample_t right;
   } stereo_frame_t;

   typedef enum logic {
      WAIT_L = 1'b0,
      WAIT_R = 1'b1
   } packer_state_e;

endpackage

// File: rtl/pcm_frame_fifo.sv
// Synchronous show-ahead FIFO of stereo frames.
//   clk, rst     : clock, synchronous active-high reset
//   push_i       : write push_data_i (ignored when full)
//   push_data_i  : frame to store
//   pop_i        : drop the head frame (ignored when empty)
//   head_o       : head frame, forced to 0 when empty
//   full_o       : DEPTH frames stored
//   empty_o      : no frames stored
//   level_o      : frames currently stored
module pcm_frame_fifo
   import pcm_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  stereo_frame_t            push_data_i,
   input  logic                     pop_i,
   output stereo_frame_t            head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   stereo_frame_t    mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             do_push_c;
   logic             do_pop_c;

   assign full_o    = (level_q == LVL_W'(DEPTH));
   assign empty_o   = (level_q == '0);
   assign level_o   = level_q;
   assign do_push_c = push_i && !full_o;
   assign do_pop_c  = pop_i && !empty_o;
   assign head_o    = empty_o ? '0 : mem_q[rd_ptr_q];

   // Next pointers and level; pointers wrap naturally since DEPTH is a power of 2
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push_c, do_pop_c})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   // Pointer and level registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: the head is masked while empty
   always_ff @(posedge clk) begin
      if (do_push_c) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/pcm_stereo_packer.sv
// Pairs left/right PCM samples into stereo frames and queues them.
//   clk, rst              : clock, synchronous active-high reset
//   pcm_valid/pcm_ready   : upstream sample handshake
//   pcm_ch, pcm_data      : sample channel and value
//   frm_valid/frm_ready   : downstream frame handshake
//   frm_left, frm_right   : head frame (0 when no frame)
//   fifo_level            : frames stored
//   sync_err              : one-cycle pulse per channel-order violation
//   err_cnt               : saturating count of sync_err pulses
module pcm_stereo_packer
   import pcm_pkg::*;
#(
   parameter int unsigned DATA_W  = 24,
   parameter int unsigned DEPTH   = 4,
   parameter logic        LEFT_CH = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pcm_valid,
   output logic                   pcm_ready,
   input  logic                   pcm_ch,
   input  logic [DATA_W-1:0]      pcm_data,
   output logic                   frm_valid,
   input  logic                   frm_ready,
   output logic [DATA_W-1:0]      frm_left,
   output logic [DATA_W-1:0]      frm_right,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic                   sync_err,
   output logic [ERR_CNT_W-1:0]   err_cnt
);

   packer_state_e          state_q, state_d;
   pcm_sample_t            hold_q, hold_d;
   logic                   sync_err_q, sync_err_d;
   logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
   logic                   accept_c;
   logic                   is_left_c;
   logic                   push_c;
   logic                   pop_c;
   logic                   fifo_full;
   logic                   fifo_empty;
   stereo_frame_t          push_frame;
   stereo_frame_t          head_frame;

   // Ready is a function of registered state only (never of pcm_valid)
   assign pcm_ready  = !rst && ((state_q == WAIT_L) || !fifo_full);
   assign accept_c   = pcm_valid && pcm_ready;
   assign is_left_c  = (pcm_ch == LEFT_CH);
   assign pop_c      = frm_ready && !fifo_empty;
   assign push_frame = '{left: hold_q, right: PCM_DATA_W'(pcm_data)};

   // Pairing FSM: only an accepted sample can move it
   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      push_c     = 1'b0;
      sync_err_d = 1'b0;
      case (state_q)
         WAIT_L: begin
            if (accept_c) begin
               if (is_left_c) begin
                  hold_d  = PCM_DATA_W'(pcm_data);
                  state_d = WAIT_R;
               end else begin
                  sync_err_d = 1'b1;
               end
            end
         end
         WAIT_R: begin
            if (accept_c) begin
               if (is_left_c) begin
                  // Newest left sample replaces the stale one
                  hold_d     = PCM_DATA_W'(pcm_data);
                  sync_err_d = 1'b1;
               end else begin
                  push_c  = 1'b1;
                  state_d = WAIT_L;
               end
            end
         end
         default: state_d = WAIT_L;
      endcase
   end

   // Counter moves on the same edge that raises the pulse
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (sync_err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
   end

   // Packer state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= WAIT_L;
         hold_q     <= '0;
         sync_err_q <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         sync_err_q <= sync_err_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   pcm_frame_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push_c),
      .push_data_i (push_frame),
      .pop_i       (pop_c),
      .head_o      (head_frame),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .level_o     (fifo_level)
   );

   assign frm_valid = !fifo_empty;
   assign frm_left  = DATA_W'(head_frame.left);
   assign frm_right = DATA_W'(head_frame.right);
   assign sync_err  = sync_err_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_pcm_stereo_packer.sv
// Self-checking bench for pcm_stereo_packer: a queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_pcm_stereo_packer;

   localparam int unsigned DATA_W  = 24;
   localparam int unsigned DEPTH   = 4;
   localparam logic        LEFT_CH = 1'b0;
   localparam logic        RIGHT_CH = ~LEFT_CH;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              pcm_valid = 1'b0;
   logic              pcm_ready;
   logic              pcm_ch = 1'b0;
   logic [DATA_W-1:0] pcm_data = '0;
   logic              frm_valid;
   logic              frm_ready = 1'b0;
   logic [DATA_W-1:0] frm_left;
   logic [DATA_W-1:0] frm_right;
   logic [2:0]        fifo_level;
   logic              sync_err;
   logic [15:0]       err_cnt;

   int vectors     = 0;
   int miscompares = 0;
   int dut_pops    = 0;

   pcm_stereo_packer #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .LEFT_CH (LEFT_CH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pcm_valid  (pcm_valid),
      .pcm_ready  (pcm_ready),
      .pcm_ch     (pcm_ch),
      .pcm_data   (pcm_data),
      .frm_valid  (frm_valid),
      .frm_ready  (frm_ready),
      .frm_left   (frm_left),
      .frm_right  (frm_right),
      .fifo_level (fifo_level),
      .sync_err   (sync_err),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an optional pending left sample plus a frame queue
   logic [DATA_W-1:0] mq_l[$];
   logic [DATA_W-1:0] mq_r[$];
   bit                pend_v   = 1'b0;
   logic [DATA_W-1:0] pend_d   = '0;
   int                m_err    = 0;
   bit                m_pulse  = 1'b0;
   bit                model_on = 1'b0;

   always @(posedge clk) begin
      bit rdy, acc, pop;
      if (rst) begin
         mq_l.delete();
         mq_r.delete();
         pend_v   = 1'b0;
         pend_d   = '0;
         m_err    = 0;
         m_pulse  = 1'b0;
         model_on = 1'b1;
      end else if (model_on) begin
         rdy = !pend_v || (mq_l.size() < DEPTH);
         acc = pcm_valid && rdy;
         pop = frm_ready && (mq_l.size() > 0);
         m_pulse = 1'b0;
         if (pop) begin
            void'(mq_l.pop_front());
            void'(mq_r.pop_front());
         end
         if (acc) begin
            if (pcm_ch == LEFT_CH) begin
               if (pend_v) m_pulse = 1'b1;
               pend_v = 1'b1;
               pend_d = pcm_data;
            end else if (!pend_v) begin
               m_pulse = 1'b1;
            end else begin
               mq_l.push_back(pend_d);
               mq_r.push_back(pcm_data);
               pend_v = 1'b0;
            end
         end
         if (m_pulse && m_err < 65535) m_err++;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (model_on) begin
         chk("pcm_ready", 32'(pcm_ready), 32'(!rst && (!pend_v || mq_l.size() < DEPTH)));
         chk("frm_valid", 32'(frm_valid), 32'(mq_l.size() > 0));
         chk("frm_left",  32'(frm_left),  (mq_l.size() > 0) ? 32'(mq_l[0]) : 32'd0);
         chk("frm_right", 32'(frm_right), (mq_r.size() > 0) ? 32'(mq_r[0]) : 32'd0);
         chk("fifo_level", 32'(fifo_level), 32'(mq_l.size()));
         chk("sync_err",  32'(sync_err),  32'(m_pulse));
         chk("err_cnt",   32'(err_cnt),   32'(m_err));
         if (frm_valid && frm_ready) dut_pops++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step();
      rst       = 1'b1;
      pcm_valid = 1'b0;
      step();
      rst = 1'b0;
   endtask

   // Offer one sample and hold it until accepted, then go idle
   task automatic send(input logic ch, input logic [DATA_W-1:0] d);
      int  n = 0;
      bit  done = 1'b0;
      bit  r;
      pcm_valid = 1'b1;
      pcm_ch    = ch;
      pcm_data  = d;
      while (!done) begin
         @(negedge clk);
         r = pcm_ready;
         step();
         if (r) done = 1'b1;
         else if (++n > 200) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
            done = 1'b1;
         end
      end
      pcm_valid = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      // 1: single frame passes straight through
      do_reset();
      frm_ready = 1'b1;
      send(LEFT_CH, 24'h123456);
      send(RIGHT_CH, 24'hABCDEF);
      @(negedge clk);
      chk("t1_valid", 32'(frm_valid), 32'd1);
      chk("t1_left",  32'(frm_left),  32'h123456);
      chk("t1_right", 32'(frm_right), 32'hABCDEF);
      chk("t1_level1", 32'(fifo_level), 32'd1);
      @(negedge clk);
      chk("t1_level0", 32'(fifo_level), 32'd0);
      chk("t1_err",   32'(err_cnt), 32'd0);

      // 2: fill to DEPTH, back-pressure, release one slot
      do_reset();
      frm_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send(LEFT_CH,  24'h100000 + 24'(i));
         send(RIGHT_CH, 24'h200000 + 24'(i));
      end
      send(LEFT_CH, 24'h100004);
      pcm_valid = 1'b1;
      pcm_ch    = RIGHT_CH;
      pcm_data  = 24'h200004;
      repeat (3) begin
         @(negedge clk);
         chk("t2_ready_full", 32'(pcm_ready), 32'd0);
         chk("t2_level4", 32'(fifo_level), 32'd4);
         chk("t2_head0", 32'(frm_left), 32'h100000);
      end
      step();
      frm_ready = 1'b1;
      @(posedge clk);
      #1;
      frm_ready = 1'b0;
      @(negedge clk);
      chk("t2_ready_after_pop", 32'(pcm_ready), 32'd1);
      chk("t2_level3", 32'(fifo_level), 32'd3);
      step();
      pcm_valid = 1'b0;
      @(negedge clk);
      chk("t2_level4b", 32'(fifo_level), 32'd4);
      step();
      frm_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("t2_drain_left",  32'(frm_left),  32'h100000 + 32'(k));
         chk("t2_drain_right", 32'(frm_right), 32'h200000 + 32'(k));
      end
      @(negedge clk);
      chk("t2_empty", 32'(frm_valid), 32'd0);

      // 3: leading right sample is dropped
      do_reset();
      frm_ready = 1'b1;
      send(RIGHT_CH, 24'h000001);
      @(negedge clk);
      chk("t3_pulse", 32'(sync_err), 32'd1);
      chk("t3_cnt",   32'(err_cnt),  32'd1);
      step();
      send(LEFT_CH,  24'h000002);
      send(RIGHT_CH, 24'h000003);
      @(negedge clk);
      chk("t3_left",  32'(frm_left),  32'h000002);
      chk("t3_right", 32'(frm_right), 32'h000003);
      chk("t3_cnt2",  32'(err_cnt),   32'd1);

      // 4: newest left wins
      do_reset();
      send(LEFT_CH, 24'h00000A);
      send(LEFT_CH, 24'h00000B);
      @(negedge clk);
      chk("t4_pulse", 32'(sync_err), 32'd1);
      chk("t4_cnt",   32'(err_cnt),  32'd1);
      step();
      send(RIGHT_CH, 24'h00000C);
      @(negedge clk);
      chk("t4_left",  32'(frm_left),  32'h00000B);
      chk("t4_right", 32'(frm_right), 32'h00000C);

      // 5: reset discards held sample and queued frames
      do_reset();
      frm_ready = 1'b0;
      send(LEFT_CH, 24'h000011);
      send(RIGHT_CH, 24'h000021);
      send(LEFT_CH, 24'h000012);
      send(RIGHT_CH, 24'h000022);
      send(RIGHT_CH, 24'h000099);
      send(LEFT_CH, 24'h000013);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_ready_in_rst", 32'(pcm_ready), 32'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("t5_valid", 32'(frm_valid), 32'd0);
      chk("t5_level", 32'(fifo_level), 32'd0);
      chk("t5_err",   32'(err_cnt), 32'd0);
      chk("t5_left",  32'(frm_left), 32'd0);
      step();
      send(RIGHT_CH, 24'h000014);
      @(negedge clk);
      chk("t5_pulse", 32'(sync_err), 32'd1);
      chk("t5_level2", 32'(fifo_level), 32'd0);

      // 6: back-to-back stream, full throughput
      do_reset();
      frm_ready = 1'b1;
      p0 = dut_pops;
      for (int i = 0; i < 100; i++) begin
         pcm_valid = 1'b1;
         pcm_ch    = (i % 2 == 0) ? LEFT_CH : RIGHT_CH;
         pcm_data  = 24'(i);
         @(negedge clk);
         chk("t6_ready", 32'(pcm_ready), 32'd1);
         chk("t6_level_le1", 32'(fifo_level <= 3'd1), 32'd1);
         step();
      end
      pcm_valid = 1'b0;
      @(negedge clk);
      step();
      chk("t6_frames", 32'(dut_pops - p0), 32'd50);
      chk("t6_err", 32'(err_cnt), 32'd0);

      // 7: error counter saturation
      do_reset();
      pcm_valid = 1'b1;
      pcm_ch    = RIGHT_CH;
      pcm_data  = 24'h0;
      repeat (65540) @(posedge clk);
      #1;
      pcm_valid = 1'b0;
      @(negedge clk);
      chk("t7_sat", 32'(err_cnt), 32'h0000FFFF);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
